// File: rtl/window_scan_counter.sv
// window_scan_counter
// Nested (column, row, channel) scan generator for walking a CNN input
// feature map. It supports a stride on col/row, two loop orders, a
// start/busy/done handshake, a per-step stall and an end-of-scan flag.
// All outputs are registered except `last`, which decodes the current indices.
module window_scan_counter #(
    parameter int COLS   = 10,
    parameter int ROWS   = 8,
    parameter int CHANS  = 1,
    parameter int STRIDE = 1,
    parameter int IW     = 7,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic          mode,
    output logic [IW-1:0] col,
    output logic [IW-1:0] row,
    output logic [CW-1:0] ch,
    output logic          valid,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limits are held one bit wider than the index. The stride sum can then
    // be compared without wrapping through 2^IW.
    localparam logic [IW:0] STEP_E  = (IW+1)'(STRIDE);
    localparam logic [IW:0] COL_LIM = (IW+1)'(COLS - 1);
    localparam logic [IW:0] ROW_LIM = (IW+1)'(ROWS - 1);
    localparam logic [CW:0] CH_LIM  = (CW+1)'(CHANS - 1);

    // Index plus stride, widened so the carry out of IW bits is kept.
    function automatic logic [IW:0] stride_sum(input logic [IW-1:0] idx);
        return {1'b0, idx} + STEP_E;
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] col_q, col_d;
    logic [IW-1:0] row_q, row_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;

    logic [IW:0]   col_sum_s;
    logic [IW:0]   row_sum_s;
    logic          col_max_s;
    logic          row_max_s;
    logic          ch_max_s;
    logic          last_s;

    // An index is at its maximum when one more stride would pass the last
    // legal position. A dimension of size 1 is therefore always at its maximum.
    assign col_sum_s = stride_sum(col_q);
    assign row_sum_s = stride_sum(row_q);
    assign col_max_s = (col_sum_s > COL_LIM);
    assign row_max_s = (row_sum_s > ROW_LIM);
    assign ch_max_s  = ({1'b0, ch_q} >= CH_LIM);
    assign last_s    = (state_q == RUN) && col_max_s && row_max_s && ch_max_s;

    // Next-state, index stepping and handshake outputs.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    mode_d  = mode;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (en) begin
                    if (last_s) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (mode_q == 1'b0) begin
                        // Column innermost, then row, then channel.
                        if (!col_max_s) begin
                            col_d = col_sum_s[IW-1:0];
                        end else begin
                            col_d = '0;
                            if (!row_max_s) begin
                                row_d = row_sum_s[IW-1:0];
                            end else begin
                                row_d = '0;
                                ch_d  = ch_q + CW'(1);
                            end
                        end
                    end else begin
                        // Channel innermost, then column, then row.
                        if (!ch_max_s) begin
                            ch_d = ch_q + CW'(1);
                        end else begin
                            ch_d = '0;
                            if (!col_max_s) begin
                                col_d = col_sum_s[IW-1:0];
                            end else begin
                                col_d = '0;
                                row_d = row_sum_s[IW-1:0];
                            end
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
                ch_d    = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                mode_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset has priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    assign col   = col_q;
    assign row   = row_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign last  = last_s;

endmodule

// File: tb/tb_window_scan_counter.sv
// Scoreboard bench for window_scan_counter. Three instances cover the default
// map, a strided 5x5 map and a 2x2x3 multi-channel map. Expected coordinate
// lists come from nested loops over the scan definition. A negedge monitor
// compares each presented coordinate against the queue head.
module tb_window_scan_counter;
    localparam int IW = 7;
    localparam int CW = 4;
    localparam int P_COLS  [3] = '{10, 5, 2};
    localparam int P_ROWS  [3] = '{8, 5, 2};
    localparam int P_CHANS [3] = '{1, 1, 3};
    localparam int P_STR   [3] = '{1, 2, 1};

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] row;
        logic [7:0] col;
        logic       last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst   [3];
    logic          start [3];
    logic          en    [3];
    logic          mode  [3];
    logic [IW-1:0] col   [3];
    logic [IW-1:0] row   [3];
    logic [CW-1:0] ch    [3];
    logic          valid [3];
    logic          last  [3];
    logic          busy  [3];
    logic          done  [3];

    exp_t exp_q [3][$];
    int   vcnt  [3];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    window_scan_counter #(.COLS(10), .ROWS(8), .CHANS(1), .STRIDE(1), .IW(IW), .CW(CW)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .en(en[0]), .mode(mode[0]),
        .col(col[0]), .row(row[0]), .ch(ch[0]), .valid(valid[0]), .last(last[0]),
        .busy(busy[0]), .done(done[0]));
    window_scan_counter #(.COLS(5), .ROWS(5), .CHANS(1), .STRIDE(2), .IW(IW), .CW(CW)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .en(en[1]), .mode(mode[1]),
        .col(col[1]), .row(row[1]), .ch(ch[1]), .valid(valid[1]), .last(last[1]),
        .busy(busy[1]), .done(done[1]));
    window_scan_counter #(.COLS(2), .ROWS(2), .CHANS(3), .STRIDE(1), .IW(IW), .CW(CW)) u2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .en(en[2]), .mode(mode[2]),
        .col(col[2]), .row(row[2]), .ch(ch[2]), .valid(valid[2]), .last(last[2]),
        .busy(busy[2]), .done(done[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mk(input int c, input int r, input int h);
        return {8'h00, 8'(h), 8'(r), 8'(c)};
    endfunction

    function automatic logic [31:0] coord(input int i);
        return {8'h00, 8'(ch[i]), 8'(row[i]), 8'(col[i])};
    endfunction

    function automatic logic [31:0] state_word(input int i);
        return {valid[i], last[i], busy[i], done[i], 4'h0, 8'(ch[i]), 8'(row[i]), 8'(col[i])};
    endfunction

    // Reference scan: plain nested loops over the legal positions in loop order.
    task automatic push_model(input int i, input logic m);
        int   s  = P_STR[i];
        int   nc = (P_COLS[i] + s - 1) / s;
        int   nr = (P_ROWS[i] + s - 1) / s;
        int   nh = P_CHANS[i];
        int   n  = nc * nr * nh;
        int   k  = 0;
        exp_t e;
        if (m == 1'b0) begin
            for (int h = 0; h < nh; h++)
                for (int r = 0; r < nr; r++)
                    for (int c = 0; c < nc; c++) begin
                        e = '{ch: 8'(h), row: 8'(r * s), col: 8'(c * s), last: (k == n - 1)};
                        exp_q[i].push_back(e);
                        k++;
                    end
        end else begin
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < nc; c++)
                    for (int h = 0; h < nh; h++) begin
                        e = '{ch: 8'(h), row: 8'(r * s), col: 8'(c * s), last: (k == n - 1)};
                        exp_q[i].push_back(e);
                        k++;
                    end
        end
    endtask

    // Monitor: valid must be high exactly while expectations are pending,
    // and the presented coordinate must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid_%0d", i), 32'(valid[i]), 32'(exp_q[i].size() != 0));
            if (valid[i] === 1'b1 && exp_q[i].size() != 0) begin
                e = exp_q[i][0];
                chk($sformatf("coord_%0d", i), coord(i), {8'h00, e.ch, e.row, e.col});
                chk($sformatf("last_%0d", i), 32'(last[i]), 32'(e.last));
                if (en[i] === 1'b1) begin
                    void'(exp_q[i].pop_front());
                    vcnt[i]++;
                end
            end else begin
                chk($sformatf("last_idle_%0d", i), 32'(last[i]), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int i, input logic m);
        start[i] = 1'b1;
        mode[i]  = m;
        tick();
        start[i] = 1'b0;
        vcnt[i]  = 0;
        push_model(i, m);
        chk("start_state", {28'h0, valid[i], busy[i], done[i], 1'b0}, 32'hC);
        chk("start_coord", coord(i), mk(0, 0, 0));
    endtask

    // Scan with en held high and mode toggled every cycle; checks exact length.
    task automatic continuous_scan(input int i, input logic m, input int n, input logic [31:0] fin);
        do_start(i, m);
        en[i] = 1'b1;
        repeat (n - 1) begin
            mode[i] = ~mode[i];
            tick();
        end
        chk("last_at_end", 32'(last[i]), 32'd1);
        chk("final_coord", coord(i), fin);
        tick();
        en[i] = 1'b0;
        chk("done_state", {28'h0, valid[i], busy[i], done[i], 1'b0}, 32'h2);
        chk("done_hold", coord(i), fin);
        chk("valid_count", 32'(vcnt[i]), 32'(n));
    endtask

    // Scan with random stall, random mode changes and ignored start pulses.
    task automatic run_scan(input int i, input logic m, input int budget);
        do_start(i, m);
        for (int c = 0; c < budget && done[i] !== 1'b1; c++) begin
            en[i]    = ($urandom_range(0, 3) != 0);
            start[i] = ($urandom_range(0, 15) == 0);
            mode[i]  = 1'($urandom);
            tick();
        end
        start[i] = 1'b0;
        en[i]    = 1'b0;
        chk("scan_done", 32'(done[i]), 32'd1);
        chk("scan_len", 32'(exp_q[i].size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; en[i] = 1'b0; mode[i] = 1'b0; vcnt[i] = 0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) chk("reset_state", state_word(i), 32'h0);

        continuous_scan(0, 1'b0, 80, mk(9, 7, 0));
        continuous_scan(1, 1'b0, 9, mk(4, 4, 0));
        continuous_scan(2, 1'b1, 12, mk(1, 1, 2));
        continuous_scan(2, 1'b0, 12, mk(1, 1, 2));

        // Stall at (4,2,0) for three cycles.
        do_start(0, 1'b0);
        en[0] = 1'b1;
        repeat (24) tick();
        chk("stall_entry", coord(0), mk(4, 2, 0));
        en[0] = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_hold", coord(0), mk(4, 2, 0));
            chk("stall_valid", 32'(valid[0]), 32'd1);
        end
        en[0] = 1'b1;
        tick();
        chk("stall_resume", coord(0), mk(5, 2, 0));
        for (int c = 0; c < 200 && done[0] !== 1'b1; c++) tick();
        en[0] = 1'b0;
        chk("stall_done", 32'(done[0]), 32'd1);
        chk("stall_len", 32'(exp_q[0].size()), 32'd0);

        // Reset in the middle of a scan at (6,3,0).
        do_start(0, 1'b0);
        en[0] = 1'b1;
        repeat (36) tick();
        chk("rst_point", coord(0), mk(6, 3, 0));
        en[0]  = 1'b0;
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        exp_q[0].delete();
        chk("rst_midrun", state_word(0), 32'h0);
        en[0] = 1'b1;
        tick();
        en[0] = 1'b0;
        chk("idle_ignores_en", state_word(0), 32'h0);

        // Randomised scans, the first restarting DUT0 after the abort.
        for (int t = 0; t < 6; t++) run_scan(t % 3, 1'($urandom), 2000);

        // start coincident with rst: reset wins.
        rst[1]   = 1'b1;
        start[1] = 1'b1;
        tick();
        rst[1]   = 1'b0;
        start[1] = 1'b0;
        chk("rst_start", state_word(1), 32'h0);
        tick();
        chk("rst_start_idle", state_word(1), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/window_scan_counter.md
# window_scan_counter

Parametrised nested scan counter that generates (column, row, channel) coordinates for walking a CNN input feature map. It supports configurable stride, multiple channels, two loop orders, a start/busy/done handshake, per-step stall and an end-of-scan flag. It sits between the layer controller, which issues `start` and `en`, and the input-buffer address generator, which consumes `col`/`row`/`ch` while `valid` is high.

## Interface
Parameters:
- `COLS`, 10, feature-map width in positions (1..2^IW).
- `ROWS`, 8, feature-map height (1..2^IW).
- `CHANS`, 1, channel count (1..2^CW).
- `STRIDE`, 1, col/row step (1..min(COLS,ROWS)).
- `IW`, 7, col/row index width.
- `CW`, 4, channel index width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a scan.
- `en` in 1: advance enable; 0 stalls the scan.
- `mode` in 1: loop order. 0 = col innermost, then row, then ch. 1 = ch innermost, then col, then row.
- `col` out IW: current column index.
- `row` out IW: current row index.
- `ch` out CW: current channel index.
- `valid` out 1: coordinate outputs are meaningful.
- `last` out 1: current coordinate is the final one of the scan.
- `busy` out 1: scan in progress.
- `done` out 1: scan complete; sticky.

## Operation
- FSM states: IDLE, RUN, DONE. The state register and all outputs are registered; `last` is the only combinational output.
- Reset: state = IDLE; `col`, `row`, `ch`, `valid`, `busy`, `done` = 0. `last` = 0 because it is gated by RUN.
- IDLE:
  - `start` = 1 moves to RUN, clears all indices to 0, sets `valid` = `busy` = 1 and latches `mode`.
  - `en` is ignored in IDLE.
- RUN, `en` = 0: all outputs hold.
- RUN, `en` = 1, not `last`: the innermost index advances.
  - col/row step by STRIDE. The legal values are 0, S, 2S, …, up to the largest multiple ≤ COLS-1 (ROWS-1 for row).
  - ch steps by 1, up to CHANS-1.
  - When the innermost index is at its maximum, it returns to 0 and the next outer index advances. This cascades outward.
- RUN, `en` = 1 and `last` = 1: move to DONE.
  - `valid` = `busy` = 0, `done` = 1.
  - Indices hold the final coordinate.
- `last` = RUN and all three indices at their maxima.
- DONE:
  - `done` stays at 1.
  - `start` re-arms exactly as from IDLE and clears `done` in the same edge.
- `start` while in RUN is ignored; the scan is not restarted.
- `mode` is sampled only on an accepted `start`. Changes during RUN have no effect.
- Arithmetic: compute next col/row as `index + STRIDE` in IW+1 bits and compare against COLS-1 / ROWS-1 before committing. Indices never wrap through 2^IW.
- Degenerate dimensions: when COLS, ROWS or CHANS = 1, that index stays 0 and always counts as at its maximum.

## Timing
- Latency: `start` sampled at edge k gives the first coordinate (0,0,0) with `valid` = 1 after edge k.
- Scan length: N = ceil(COLS/STRIDE) · ceil(ROWS/STRIDE) · CHANS.
  - With `en` held at 1, `valid` is high for exactly N cycles.
  - `done` rises on the edge that consumes the final coordinate.
- Each coordinate is consumed on a rising edge where `valid` = 1 and `en` = 1.
- `rst` has priority over every other input. In any state it returns the block to IDLE on the next edge and aborts any scan in progress.
- `start` and `rst` in the same cycle: reset wins.

## Test plan
- Default parameters, mode 0, `start` then `en` = 1 continuously:
  - 80 valid cycles.
  - Sequence (0,0,0), (1,0,0), …, (9,0,0), (0,1,0), …
  - `last` only at (9,7,0).
  - `done` = 1 from the following cycle, with indices held at (9,7,0).
- COLS = 5, ROWS = 5, STRIDE = 2: col and row each take only the values 0, 2, 4; 9 valid cycles; `last` at (4,4,0).
- CHANS = 3, COLS = 2, ROWS = 2, mode 1:
  - Order (0,0,0), (0,0,1), (0,0,2), (1,0,0), …, (1,1,2).
  - 12 valid cycles.
  - Toggling `mode` mid-run does not change the order.
- Stall: deassert `en` for 3 cycles at (4,2,0). Outputs hold (4,2,0) with `valid` = 1 for those 3 cycles, then the scan resumes at (5,2,0).
- Reset mid-run: `rst` at (6,3,0) gives all outputs 0 and IDLE on the next edge. A following `start` scans again from (0,0,0).
- Handshake:
  - `start` pulses during RUN are ignored; the scan length is unchanged.
  - `start` in DONE clears `done` and restarts at (0,0,0) one cycle later.
  - `start` coincident with `rst` leaves the block in IDLE.
